// File: rtl/airi5c_sba_sequencer.sv
// Turns single-word host reads/writes into Debug Module SBA register sequences on DMI.
// Best case accept->rsp_valid: 7 cycles (+2 for the sbcs config write); req_ready only in IDLE, one DMI op in flight.
module airi5c_sba_sequencer #(
    parameter int POLL_MAX  = 16,
    parameter int RETRY_MAX = 8
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        dmi_req_valid,
    input  logic        dmi_req_ready,
    output logic [6:0]  dmi_addr,
    output logic [31:0] dmi_wdata,
    output logic [1:0]  dmi_op,
    input  logic        dmi_rsp_valid,
    input  logic [31:0] dmi_rsp_data,
    input  logic [1:0]  dmi_rsp_op
);

    localparam logic [6:0]  A_SBCS   = 7'h38;
    localparam logic [6:0]  A_SBADDR = 7'h39;
    localparam logic [6:0]  A_SBDATA = 7'h3C;
    localparam logic [31:0] CFG_WORD = 32'h0054_7000;
    localparam logic [1:0]  OP_RD    = 2'd1;
    localparam logic [1:0]  OP_WR    = 2'd2;
    localparam int          PW       = $clog2(POLL_MAX + 1);
    localparam int          RW       = $clog2(RETRY_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_ADDR, S_DATA, S_POLL, S_RDATA, S_CLR, S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic           wait_q, wait_d;
    logic           cfg_done_q, cfg_done_d;
    logic           err_q, err_d;
    logic           we_q, we_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [PW-1:0]  poll_q, poll_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic           fail;
    logic           dmi_state;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= S_IDLE;
            wait_q     <= 1'b0;
            cfg_done_q <= 1'b0;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            poll_q     <= '0;
            retry_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            cfg_done_q <= cfg_done_d;
            err_q      <= err_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            poll_q     <= poll_d;
            retry_q    <= retry_d;
        end
    end

    assign dmi_state     = !(state_q inside {S_IDLE, S_RESP});
    assign dmi_req_valid = dmi_state && !wait_q;
    // Gated with nRESET so the host sees no ready while reset is held.
    assign req_ready     = nRESET && (state_q == S_IDLE);
    assign rsp_valid     = (state_q == S_RESP);
    assign rsp_err       = rsp_valid && err_q;
    assign rsp_rdata     = (rsp_valid && !err_q && !we_q) ? rdata_q : 32'h0;

    always_comb begin
        dmi_addr  = 7'h0;
        dmi_wdata = 32'h0;
        dmi_op    = 2'd0;
        case (state_q)
            S_CFG, S_CLR: begin dmi_addr = A_SBCS;   dmi_wdata = CFG_WORD; dmi_op = OP_WR; end
            S_ADDR:       begin dmi_addr = A_SBADDR; dmi_wdata = addr_q;   dmi_op = OP_WR; end
            S_DATA:       begin dmi_addr = A_SBDATA; dmi_wdata = wdata_q;  dmi_op = OP_WR; end
            S_POLL:       begin dmi_addr = A_SBCS;   dmi_op = OP_RD; end
            S_RDATA:      begin dmi_addr = A_SBDATA; dmi_op = OP_RD; end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        cfg_done_d = cfg_done_q;
        err_d      = err_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        poll_d     = poll_q;
        retry_d    = retry_q;
        fail       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = {req_addr[31:2], 2'b00};
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    poll_d  = '0;
                    retry_d = '0;
                    wait_d  = 1'b0;
                    state_d = cfg_done_q ? S_ADDR : S_CFG;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: begin
                if (!wait_q) begin
                    if (dmi_req_ready) wait_d = 1'b1;
                end else if (dmi_rsp_valid) begin
                    wait_d  = 1'b0;
                    retry_d = '0;
                    if (dmi_rsp_op == 2'd3) begin
                        // Busy answer: same state re-issues the identical op.
                        if (retry_q < RW'(RETRY_MAX)) retry_d = retry_q + RW'(1);
                        else                          fail    = 1'b1;
                    end else if (dmi_rsp_op != 2'd0) begin
                        fail = 1'b1;
                    end else begin
                        case (state_q)
                            S_CFG: begin
                                cfg_done_d = 1'b1;
                                state_d    = S_ADDR;
                            end
                            S_ADDR: state_d = we_q ? S_DATA : S_POLL;
                            S_DATA: state_d = S_POLL;
                            S_POLL: begin
                                if (dmi_rsp_data[22] || (dmi_rsp_data[14:12] != 3'd0)) begin
                                    fail = 1'b1;
                                end else if (dmi_rsp_data[21]) begin
                                    if (poll_q + PW'(1) == PW'(POLL_MAX)) fail   = 1'b1;
                                    else                                  poll_d = poll_q + PW'(1);
                                end else begin
                                    state_d = we_q ? S_RESP : S_RDATA;
                                end
                            end
                            S_RDATA: begin
                                rdata_d = dmi_rsp_data;
                                state_d = S_RESP;
                            end
                            default: state_d = S_RESP;
                        endcase
                    end
                end
            end
        endcase

        // A failure inside the recovery write itself reports instead of looping.
        if (fail) begin
            err_d      = 1'b1;
            cfg_done_d = 1'b0;
            retry_d    = '0;
            wait_d     = 1'b0;
            state_d    = (state_q == S_CLR) ? S_RESP : S_CLR;
        end
    end

endmodule
